// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: state encodings,
// default widths, the WAIT timeout default and the owner encoding.
package ram_arbiter_pkg;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  // Codes are shown on the seven-segment display, so they are fixed.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ISSUE = 4'd1,
    ST_WAIT  = 4'd2,
    ST_RESP  = 4'd3
  } state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory
// controller.
//   a_* / b_*  : request (req, we, addr, wdata) and response (ack, err, rdata)
//   mem_*      : strobes, latched address/data, done and read data
// Modports:
//   slave  - the arbiter
//   master - the requesters and the memory controller (the environment)
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_en;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output mem_en, mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  mem_en, mem_re, mem_we, mem_addr, mem_wdata,
    output mem_done, mem_rdata
  );

endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two requesters access to one memory
// controller, one transaction at a time, with a bounded wait for mem_done.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   bus   - requester A/B handshakes and memory controller signals (slave)
//   owner - current or last grant (0 = A, 1 = B)
//   state - FSM state code for the seven-segment display
//
// state | meaning
// IDLE  | sample a_req/b_req, grant and latch the winner's request
// ISSUE | one-cycle mem_re or mem_we strobe
// WAIT  | wait for mem_done, give up after TIMEOUT cycles
// RESP  | one-cycle ack with err/rdata to the owner
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus,
  output logic           owner,
  output logic [3:0]     state
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Last WAIT cycle: the counter starts at 0, so WAIT lasts TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    grant_b = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          // On a tie the requester that was not granted last wins.
          grant_b = bus.b_req && (!bus.a_req || (owner_q == OWNER_A));
          owner_d = grant_b;
          we_d    = grant_b ? bus.b_we    : bus.a_we;
          addr_d  = grant_b ? bus.b_addr  : bus.a_addr;
          wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // mem_done wins over a timeout landing in the same cycle.
        if (bus.mem_done) begin
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : bus.mem_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  assign bus.mem_en    = (state_q != ST_IDLE);
  assign bus.mem_re    = (state_q == ST_ISSUE) && !we_q;
  assign bus.mem_we    = (state_q == ST_ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.a_ack   = (state_q == ST_RESP) && (owner_q == OWNER_A);
  assign bus.b_ack   = (state_q == ST_RESP) && (owner_q == OWNER_B);
  assign bus.a_err   = bus.a_ack && err_q;
  assign bus.b_err   = bus.b_ack && err_q;
  assign bus.a_rdata = bus.a_ack ? rdata_q : '0;
  assign bus.b_rdata = bus.b_ack ? rdata_q : '0;

  assign owner = owner_q;
  assign state = state_q;

endmodule
